acq_sequencer: RTL and testbench

- Frame-level controller for the LVDS ADC capture datapath.
- Sits between the AXI-lite control register bank and the lvds_input capture/packing path, in the AXI-stream clock domain.
- Arms on a register command, starts a frame on the rising edge of the external sync, and gates capture with `capture_en`.
- Counts accepted sample words, tags the last word of each frame for TLAST generation, and reports status and error flags.

---
 rtl/acq_sequencer.sv | 143 ++++++++++++++
 tb/tb_acq_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// Frame-level acquisition sequencer: arms on a register command, starts frames on
// the synchronised external sync edge, gates capture and tags the last word of each frame.
module acq_sequencer #(
  parameter int CNT_W       = 24,
  parameter int FRM_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             m00_axis_aclk,
  input  logic             m00_axis_aresetn,
  input  logic             sync_in,
  input  logic             cfg_rt,
  input  logic             cfg_single,
  input  logic             cfg_abort,
  input  logic             cfg_clear,
  input  logic [CNT_W-1:0] cfg_frame_len,
  input  logic [FRM_W-1:0] cfg_frames,
  input  logic             sample_valid,
  input  logic             fifo_full,
  output logic             capture_en,
  output logic             sample_last,
  output logic             frame_done,
  output logic             busy,
  output logic             armed,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             overflow,
  output logic             sync_missed,
  output logic             aborted
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_d;
  logic                   sync_rise;
  logic                   rt_d;
  logic                   rt_mode;
  logic                   rt_rise;
  logic [FRM_W-1:0]       frames_left;
  logic [CNT_W-1:0]       sample_cnt;
  logic [CNT_W-1:0]       frame_len_q;
  logic [CNT_W-1:0]       len_m1;
  logic                   in_capture;
  logic                   ovf_hit;
  logic                   last_word;

  // sync_rise is itself registered, so it lands SYNC_STAGES+1 cycles after the pin edge
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      sync_ff   <= '0;
      sync_d    <= 1'b0;
      sync_rise <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], sync_in};
      sync_d    <= sync_ff[SYNC_STAGES-1];
      sync_rise <= sync_ff[SYNC_STAGES-1] & ~sync_d;
    end
  end

  assign in_capture  = (state == ST_CAPTURE);
  assign rt_rise     = cfg_rt & ~rt_d;
  assign len_m1      = frame_len_q - CNT_W'(1);
  assign ovf_hit     = in_capture & sample_valid & fifo_full;
  // Abort and overflow both suppress the last-word tag of the same cycle
  assign last_word   = in_capture & sample_valid & ~fifo_full & ~cfg_abort &
                       (sample_cnt == len_m1);
  assign sample_last = last_word;
  assign capture_en  = in_capture;
  assign busy        = (state != ST_IDLE);
  assign armed       = (state == ST_ARMED);

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state       <= ST_IDLE;
      rt_d        <= 1'b0;
      rt_mode     <= 1'b0;
      frames_left <= '0;
      sample_cnt  <= '0;
      frame_len_q <= '0;
      frame_done  <= 1'b0;
    end else begin
      rt_d       <= cfg_rt;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rt_rise) begin
            state   <= ST_ARMED;
            rt_mode <= 1'b1;
          end else if (cfg_single) begin
            state       <= ST_ARMED;
            rt_mode     <= 1'b0;
            frames_left <= (cfg_frames == '0) ? FRM_W'(1) : cfg_frames;
          end
        end
        ST_ARMED: begin
          if (cfg_abort) begin
            state <= ST_IDLE;
          end else if (sync_rise) begin
            state       <= ST_CAPTURE;
            sample_cnt  <= '0;
            frame_len_q <= cfg_frame_len;
          end
        end
        ST_CAPTURE: begin
          if (sample_valid) sample_cnt <= sample_cnt + CNT_W'(1);
          if (cfg_abort || ovf_hit) begin
            state <= ST_IDLE;
          end else if (last_word) begin
            frame_done <= 1'b1;
            if (rt_mode) begin
              state <= cfg_rt ? ST_ARMED : ST_IDLE;
            end else if (frames_left > FRM_W'(1)) begin
              state       <= ST_ARMED;
              frames_left <= frames_left - FRM_W'(1);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins; the counter clear wins
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      overflow    <= 1'b0;
      sync_missed <= 1'b0;
      aborted     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      overflow    <= (overflow & ~cfg_clear) | ovf_hit;
      sync_missed <= (sync_missed & ~cfg_clear) | (in_capture & sync_rise);
      aborted     <= (aborted & ~cfg_clear) | (in_capture & (cfg_abort | ovf_hit));
      if (cfg_clear)      frame_cnt <= '0;
      else if (last_word) frame_cnt <= frame_cnt + FRM_W'(1);
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: a frame-level reference model checked every cycle, plus
// directed scenarios with hand-computed expectations on a default and a CNT_W=4 instance.
module tb_acq_sequencer;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_in, cfg_rt, cfg_single, cfg_abort, cfg_clear;
  logic [23:0] cfg_frame_len;
  logic [15:0] cfg_frames;
  logic        sample_valid, fifo_full;

  logic        capture_en, sample_last, frame_done, busy, armed;
  logic [15:0] frame_cnt;
  logic        overflow, sync_missed, aborted;

  logic        s_capture_en, s_sample_last, s_frame_done, s_busy, s_armed;
  logic [15:0] s_frame_cnt;
  logic        s_overflow, s_sync_missed, s_aborted;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acq_sequencer #(.CNT_W(24), .FRM_W(16), .SYNC_STAGES(S)) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .sync_in(sync_in),
    .cfg_rt(cfg_rt), .cfg_single(cfg_single), .cfg_abort(cfg_abort),
    .cfg_clear(cfg_clear), .cfg_frame_len(cfg_frame_len), .cfg_frames(cfg_frames),
    .sample_valid(sample_valid), .fifo_full(fifo_full),
    .capture_en(capture_en), .sample_last(sample_last), .frame_done(frame_done),
    .busy(busy), .armed(armed), .frame_cnt(frame_cnt), .overflow(overflow),
    .sync_missed(sync_missed), .aborted(aborted)
  );

  acq_sequencer #(.CNT_W(4), .FRM_W(16), .SYNC_STAGES(S)) dut_small (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .sync_in(sync_in),
    .cfg_rt(cfg_rt), .cfg_single(cfg_single), .cfg_abort(cfg_abort),
    .cfg_clear(cfg_clear), .cfg_frame_len(cfg_frame_len[3:0]), .cfg_frames(cfg_frames),
    .sample_valid(sample_valid), .fifo_full(fifo_full),
    .capture_en(s_capture_en), .sample_last(s_sample_last), .frame_done(s_frame_done),
    .busy(s_busy), .armed(s_armed), .frame_cnt(s_frame_cnt), .overflow(s_overflow),
    .sync_missed(s_sync_missed), .aborted(s_aborted)
  );

  // Frame-level reference: waiting for a sync, or inside a frame counting words down
  bit          m_waiting, m_in_frame, m_rt, m_rt_prev, m_done;
  int          m_words_left, m_bursts;
  logic [15:0] m_frame_cnt;
  bit          m_ovf, m_miss, m_abt;
  logic [S+1:0] m_hist;
  bit          t_rise, t_rt_rise, t_inc, t_ovf, t_miss, t_abt;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_waiting = 0; m_in_frame = 0; m_rt = 0; m_rt_prev = 0; m_done = 0;
      m_words_left = 0; m_bursts = 0; m_frame_cnt = '0;
      m_ovf = 0; m_miss = 0; m_abt = 0; m_hist = '0;
    end else begin
      t_rise    = m_hist[S] & ~m_hist[S+1];
      m_hist    = {m_hist[S:0], sync_in};
      t_rt_rise = cfg_rt & ~m_rt_prev;
      m_rt_prev = cfg_rt;
      t_inc = 0; t_ovf = 0; t_miss = 0; t_abt = 0; m_done = 0;
      if (m_in_frame) begin
        t_miss = t_rise;
        t_ovf  = sample_valid && fifo_full;
        if (cfg_abort || t_ovf) begin
          m_in_frame = 0;
          t_abt = 1;
        end else if (sample_valid) begin
          if (m_words_left == 1) begin
            m_done = 1; t_inc = 1; m_in_frame = 0;
            if (m_rt) m_waiting = cfg_rt;
            else if (m_bursts > 1) begin
              m_bursts--;
              m_waiting = 1;
            end
          end else begin
            m_words_left--;
          end
        end
      end else if (m_waiting) begin
        if (cfg_abort) m_waiting = 0;
        else if (t_rise) begin
          m_waiting = 0;
          m_in_frame = 1;
          m_words_left = (cfg_frame_len == 0) ? (1 << 24) : int'(cfg_frame_len);
        end
      end else begin
        if (t_rt_rise) begin
          m_waiting = 1; m_rt = 1;
        end else if (cfg_single) begin
          m_waiting = 1; m_rt = 0;
          m_bursts = (cfg_frames == 0) ? 1 : int'(cfg_frames);
        end
      end
      m_ovf  = (m_ovf  & ~cfg_clear) | t_ovf;
      m_miss = (m_miss & ~cfg_clear) | t_miss;
      m_abt  = (m_abt  & ~cfg_clear) | t_abt;
      m_frame_cnt = cfg_clear ? 16'd0 : m_frame_cnt + (t_inc ? 16'd1 : 16'd0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Word positions of sample_last, and done pulses, as seen by the bench
  int word_idx = 0, done_cnt = 0, s_word_idx = 0;
  int last_q[$];
  int s_last_q[$];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      checkOutput("capture_en", capture_en, m_in_frame);
      checkOutput("busy", busy, m_waiting | m_in_frame);
      checkOutput("armed", armed, m_waiting);
      checkOutput("sample_last", sample_last,
                  m_in_frame && sample_valid && !fifo_full && !cfg_abort && m_words_left == 1);
      checkOutput("frame_done", frame_done, m_done);
      checkOutput("frame_cnt", frame_cnt, m_frame_cnt);
      checkOutput("overflow", overflow, m_ovf);
      checkOutput("sync_missed", sync_missed, m_miss);
      checkOutput("aborted", aborted, m_abt);
    end
    if (capture_en && sample_valid) begin
      word_idx++;
      if (sample_last) last_q.push_back(word_idx);
    end
    if (frame_done) done_cnt++;
    if (s_capture_en && sample_valid) begin
      s_word_idx++;
      if (s_sample_last) s_last_q.push_back(s_word_idx);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit single, input bit abort, input bit clear);
    cfg_single = single; cfg_abort = abort; cfg_clear = clear;
    cycle();
    cfg_single = 1'b0; cfg_abort = 1'b0; cfg_clear = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    sync_in = 0; cfg_rt = 0; cfg_single = 0; cfg_abort = 0; cfg_clear = 0;
    sample_valid = 1'b1; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  // Returns cycles from sync assertion until capture_en, or 12 if it never rose
  task automatic syncPulse(output int lat);
    sync_in = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      lat++;
      if (lat == 3) sync_in = 1'b0;
      if (capture_en) break;
    end
    sync_in = 1'b0;
  endtask

  function automatic int lastPos(input int k, input int base);
    return (last_q.size() > k) ? last_q[k] - base : -1;
  endfunction

  int lat, wb, qb, db, g;

  initial begin
    cfg_frame_len = 24'd8;
    cfg_frames = 16'd3;
    resetDut();

    $display("[TB] reset state");
    checkOutput("rst_capture_en", capture_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_armed", armed, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_flags", {overflow, sync_missed, aborted}, 0);

    $display("[TB] single burst of 3 x 8");
    wb = word_idx; qb = last_q.size(); db = done_cnt;
    applyStimulus(1, 0, 0);
    checkOutput("single_armed", armed, 1);
    for (int f = 0; f < 3; f++) begin
      syncPulse(lat);
      checkOutput("sync_latency", lat, 4);
      repeat (14) cycle();
    end
    checkOutput("burst_last1", lastPos(qb, wb), 8);
    checkOutput("burst_last2", lastPos(qb + 1, wb), 16);
    checkOutput("burst_last3", lastPos(qb + 2, wb), 24);
    checkOutput("burst_done", done_cnt - db, 3);
    checkOutput("burst_frame_cnt", frame_cnt, 3);
    checkOutput("burst_idle", busy, 0);
    syncPulse(lat);
    repeat (4) cycle();
    checkOutput("sync4_busy", busy, 0);
    checkOutput("sync4_missed", sync_missed, 0);

    $display("[TB] real-time mode");
    resetDut();
    cfg_frame_len = 24'd100;
    cfg_rt = 1'b1;
    repeat (2) cycle();
    for (int f = 0; f < 5; f++) begin
      syncPulse(lat);
      repeat (3996) cycle();
    end
    checkOutput("rt_frame_cnt5", frame_cnt, 5);
    checkOutput("rt_armed", armed, 1);
    syncPulse(lat);
    repeat (50) cycle();
    cfg_rt = 1'b0;
    repeat (80) cycle();
    checkOutput("rt_frame_cnt6", frame_cnt, 6);
    checkOutput("rt_idle", busy, 0);

    $display("[TB] sync during frame");
    resetDut();
    cfg_frame_len = 24'd1000; cfg_frames = 16'd1;
    wb = word_idx; qb = last_q.size(); db = done_cnt;
    applyStimulus(1, 0, 0);
    syncPulse(lat);
    g = 0;
    while (word_idx - wb < 399 && g < 1200) begin cycle(); g++; end
    sync_in = 1'b1;
    repeat (3) cycle();
    sync_in = 1'b0;
    g = 0;
    while (done_cnt == db && g < 1200) begin cycle(); g++; end
    checkOutput("miss_flag", sync_missed, 1);
    checkOutput("miss_last_pos", lastPos(qb, wb), 1000);
    checkOutput("miss_frame_cnt", frame_cnt, 1);
    applyStimulus(0, 0, 1);
    checkOutput("clear_missed", sync_missed, 0);
    checkOutput("clear_frame_cnt", frame_cnt, 0);

    $display("[TB] overflow");
    resetDut();
    cfg_frame_len = 24'd16;
    wb = word_idx; db = done_cnt;
    applyStimulus(1, 0, 0);
    syncPulse(lat);
    g = 0;
    while (word_idx - wb < 4 && g < 50) begin cycle(); g++; end
    fifo_full = 1'b1;
    cycle();
    fifo_full = 1'b0;
    checkOutput("ovf_capture_en", capture_en, 0);
    checkOutput("ovf_flags", {overflow, aborted}, 2'b11);
    repeat (20) cycle();
    checkOutput("ovf_no_done", done_cnt - db, 0);
    checkOutput("ovf_idle", busy, 0);

    $display("[TB] abort");
    resetDut();
    cfg_frame_len = 24'd8;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("abort_armed_busy", busy, 0);
    checkOutput("abort_armed_flag", aborted, 0);
    wb = word_idx; db = done_cnt;
    applyStimulus(1, 0, 0);
    syncPulse(lat);
    g = 0;
    while (word_idx - wb < 7 && g < 50) begin cycle(); g++; end
    cfg_abort = 1'b1;
    #1;
    checkOutput("abort_last_untagged", sample_last, 0);
    cycle();
    cfg_abort = 1'b0;
    checkOutput("abort_cap_flag", aborted, 1);
    checkOutput("abort_cap_busy", busy, 0);
    repeat (3) cycle();
    checkOutput("abort_no_done", done_cnt - db, 0);

    $display("[TB] reset mid-capture");
    resetDut();
    cfg_frame_len = 24'd20; cfg_frames = 16'd2;
    applyStimulus(1, 0, 0);
    syncPulse(lat);
    repeat (30) cycle();
    syncPulse(lat);
    repeat (5) cycle();
    checkOutput("pre_rst_frame_cnt", frame_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_outputs",
                {capture_en, sample_last, frame_done, busy, armed, overflow, sync_missed, aborted}, 0);
    checkOutput("async_rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    syncPulse(lat);
    checkOutput("post_rst_sync_ignored", busy, 0);

    $display("[TB] frame_len 0 on CNT_W=4");
    resetDut();
    cfg_frame_len = 24'd0; cfg_frames = 16'd1;
    wb = s_word_idx; qb = s_last_q.size();
    applyStimulus(1, 0, 0);
    syncPulse(lat);
    repeat (24) cycle();
    checkOutput("len0_last_pos", (s_last_q.size() > qb) ? s_last_q[qb] - wb : -1, 16);
    checkOutput("len0_frame_cnt", s_frame_cnt, 1);
    checkOutput("len0_idle", s_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
